// File: rtl/network_trigger_ctrl.sv
// ---------------------------------------------------------------------------
// network_trigger_ctrl
//
// Network-level controller for the trigger instances of one actor network.
// Launches every trigger with a single broadcast start pulse, folds the
// per-trigger status lines into registered network-wide broadcasts, tracks
// late-arriving external data through a sticky flag, and re-launches the
// network when that data arrives before the network goes quiet.
//
// Parameters
//   NUM_ACTORS        number of trigger instances (>= 1)
//   NUM_INPUTS        number of input stages raising enqueue strobes (>= 1)
//
// Ports
//   ap_clk            clock, rising edge
//   ap_rst_n          asynchronous active-low reset
//   ap_start          network start request (level, sampled in IDLE)
//   ap_ready          one-cycle pulse when ap_start is accepted
//   ap_done           one-cycle pulse when the network finishes
//   ap_idle           high while in IDLE
//   trig_start        broadcast start to every trigger's ap_start
//   actor_sleep       per-trigger sleep
//   actor_sync_exec   per-trigger sync_exec
//   actor_sync_wait   per-trigger sync_wait
//   actor_idle        per-trigger ap_idle (used combinationally in RUN)
//   enq_strobe        per-input-stage token enqueue pulses
//   all_sleep         registered AND of actor_sleep (RUN only)
//   all_sync          registered AND of actor_sync_exec | actor_sync_wait
//   all_sync_wait     registered AND of actor_sync_wait
//   external_enqueue  sticky "new external data arrived" flag
//   round_count       launches since the last accepted ap_start
//
// States
//   state | meaning
//   IDLE  | waiting for ap_start; triggers are idle
//   START | one cycle, trig_start broadcast to all triggers
//   RUN   | network executing; watch for all-idle
//   DONE  | one cycle, ap_done pulse
// ---------------------------------------------------------------------------
module network_trigger_ctrl #(
    parameter int NUM_ACTORS = 4,
    parameter int NUM_INPUTS = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  trig_start,
    input  logic [NUM_ACTORS-1:0] actor_sleep,
    input  logic [NUM_ACTORS-1:0] actor_sync_exec,
    input  logic [NUM_ACTORS-1:0] actor_sync_wait,
    input  logic [NUM_ACTORS-1:0] actor_idle,
    input  logic [NUM_INPUTS-1:0] enq_strobe,
    output logic                  all_sleep,
    output logic                  all_sync,
    output logic                  all_sync_wait,
    output logic                  external_enqueue,
    output logic [31:0]           round_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_all_sleep;
    logic        r_all_sync;
    logic        r_all_sync_wait;
    logic        r_ext_enq;
    logic [31:0] r_round_count;

    logic        w_accept;
    logic        w_all_idle;
    logic        w_strobe;
    logic        w_relaunch;
    logic        w_in_run;

    assign w_all_idle = &actor_idle;
    assign w_strobe   = |enq_strobe;
    assign w_in_run   = (r_state == S_RUN);
    assign w_accept   = (r_state == S_IDLE) && ap_start;
    assign w_relaunch = w_in_run && w_all_idle && r_ext_enq;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_all_idle) begin
                    // Data that arrived after launch may not have been seen by
                    // the triggers, so run another round instead of finishing.
                    w_state_nxt = r_ext_enq ? S_START : S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    always_comb begin
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        ap_idle    = 1'b0;
        trig_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ap_idle  = 1'b1;
                ap_ready = ap_start;
            end
            S_START: begin
                trig_start = 1'b1;
            end
            S_RUN: begin
            end
            S_DONE: begin
                ap_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Aggregates: gated to RUN because idle triggers report sleep/sync_wait,
    // which would otherwise leak a stale "all asleep" into the first RUN cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_all_sleep     <= 1'b0;
            r_all_sync      <= 1'b0;
            r_all_sync_wait <= 1'b0;
        end else if (w_in_run) begin
            r_all_sleep     <= &actor_sleep;
            r_all_sync      <= &(actor_sync_exec | actor_sync_wait);
            r_all_sync_wait <= &actor_sync_wait;
        end else begin
            r_all_sleep     <= 1'b0;
            r_all_sync      <= 1'b0;
            r_all_sync_wait <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky external-enqueue flag. A new strobe always wins over either
    // clearing condition so no token is ever dropped.
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ext_enq <= 1'b0;
        end else if (w_accept) begin
            r_ext_enq <= 1'b0;
        end else if (r_state != S_IDLE && w_strobe) begin
            r_ext_enq <= 1'b1;
        end else if (r_all_sync || w_relaunch) begin
            r_ext_enq <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Launch counter
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_round_count <= 32'd0;
        end else if (w_accept) begin
            r_round_count <= 32'd0;
        end else if (r_state == S_START) begin
            r_round_count <= r_round_count + 32'd1;
        end
    end

    assign all_sleep        = r_all_sleep;
    assign all_sync         = r_all_sync;
    assign all_sync_wait    = r_all_sync_wait;
    assign external_enqueue = r_ext_enq;
    assign round_count      = r_round_count;

endmodule

// File: tb/tb_network_trigger_ctrl.sv
module tb_network_trigger_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic        trig_start;
    logic [3:0]  actor_sleep;
    logic [3:0]  actor_sync_exec;
    logic [3:0]  actor_sync_wait;
    logic [3:0]  actor_idle;
    logic [0:0]  enq_strobe;
    logic        all_sleep;
    logic        all_sync;
    logic        all_sync_wait;
    logic        external_enqueue;
    logic [31:0] round_count;

    int n_tests = 0;
    int n_fail  = 0;

    network_trigger_ctrl #(.NUM_ACTORS(4), .NUM_INPUTS(1)) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_ready         (ap_ready),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .trig_start       (trig_start),
        .actor_sleep      (actor_sleep),
        .actor_sync_exec  (actor_sync_exec),
        .actor_sync_wait  (actor_sync_wait),
        .actor_idle       (actor_idle),
        .enq_strobe       (enq_strobe),
        .all_sleep        (all_sleep),
        .all_sync         (all_sync),
        .all_sync_wait    (all_sync_wait),
        .external_enqueue (external_enqueue),
        .round_count      (round_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ap_rst_n        = 1'b0;
        ap_start        = 1'b0;
        actor_sleep     = 4'h0;
        actor_sync_exec = 4'h0;
        actor_sync_wait = 4'h0;
        actor_idle      = 4'h0;
        enq_strobe      = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_idle",   {31'd0, ap_idle},          32'd1);
        chk("rst_ready",  {31'd0, ap_ready},         32'd0);
        chk("rst_done",   {31'd0, ap_done},          32'd0);
        chk("rst_trig",   {31'd0, trig_start},       32'd0);
        chk("rst_sleep",  {31'd0, all_sleep},        32'd0);
        chk("rst_sync",   {31'd0, all_sync},         32'd0);
        chk("rst_syncw",  {31'd0, all_sync_wait},    32'd0);
        chk("rst_ext",    {31'd0, external_enqueue}, 32'd0);
        chk("rst_rc",     round_count,               32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Idle triggers report sleep/sync_wait; aggregates must stay 0 in IDLE
        tick();
        actor_idle      = 4'hF;
        actor_sleep     = 4'hF;
        actor_sync_wait = 4'hF;
        tick();
        chk("idle_gate_sleep", {31'd0, all_sleep},     32'd0);
        chk("idle_gate_syncw", {31'd0, all_sync_wait}, 32'd0);
        ap_start = 1'b1;
        #1;
        chk("r1_ready", {31'd0, ap_ready}, 32'd1);

        tick(); // START
        ap_start = 1'b0;
        chk("r1_start_trig", {31'd0, trig_start}, 32'd1);
        chk("r1_start_rdy",  {31'd0, ap_ready},   32'd0);
        chk("r1_start_idle", {31'd0, ap_idle},    32'd0);
        chk("r1_start_rc",   round_count,         32'd0);

        tick(); // first RUN cycle
        chk("r1_run_trig",   {31'd0, trig_start},    32'd0);
        chk("r1_run_rc",     round_count,            32'd1);
        chk("r1_first_slp",  {31'd0, all_sleep},     32'd0);
        chk("r1_first_sw",   {31'd0, all_sync_wait}, 32'd0);
        actor_idle      = 4'h0;
        actor_sleep     = 4'h0;
        actor_sync_wait = 4'h0;
        tick();
        tick();
        chk("r1_slp_low",  {31'd0, all_sleep}, 32'd0);
        chk("r1_done_low", {31'd0, ap_done},   32'd0);
        actor_sleep = 4'hF;
        tick();
        chk("r1_slp_set", {31'd0, all_sleep}, 32'd1);
        actor_sleep = 4'h0;
        tick();
        chk("r1_slp_clr", {31'd0, all_sleep}, 32'd0);

        actor_sync_exec = 4'b0011;
        actor_sync_wait = 4'b1100;
        tick();
        chk("mix_sync",  {31'd0, all_sync},      32'd1);
        chk("mix_syncw", {31'd0, all_sync_wait}, 32'd0);
        actor_sync_wait = 4'hF;
        tick();
        chk("full_sync",  {31'd0, all_sync},      32'd1);
        chk("full_syncw", {31'd0, all_sync_wait}, 32'd1);
        actor_sync_exec = 4'h0;
        actor_sync_wait = 4'h0;
        tick();
        chk("clr_sync",  {31'd0, all_sync},      32'd0);
        chk("clr_syncw", {31'd0, all_sync_wait}, 32'd0);
        chk("r1_ext",    {31'd0, external_enqueue}, 32'd0);

        actor_idle = 4'hF;
        #1;
        chk("r1_run_nodone", {31'd0, ap_done}, 32'd0);
        tick(); // DONE
        chk("r1_done",      {31'd0, ap_done}, 32'd1);
        chk("r1_done_idle", {31'd0, ap_idle}, 32'd0);
        chk("r1_done_rc",   round_count,      32'd1);
        ap_start = 1'b1;
        #1;
        chk("r1_done_rdy", {31'd0, ap_ready}, 32'd0);
        tick(); // IDLE, start held -> accepted at once
        chk("r2_idle_done", {31'd0, ap_done},  32'd0);
        chk("r2_idle",      {31'd0, ap_idle},  32'd1);
        chk("r2_ready",     {31'd0, ap_ready}, 32'd1);

        tick(); // START
        ap_start   = 1'b0;
        actor_idle = 4'h0;
        chk("r2_start_trig", {31'd0, trig_start}, 32'd1);
        chk("r2_start_rc",   round_count,         32'd0);
        tick(); // RUN
        enq_strobe = 1'b1;
        tick();
        enq_strobe = 1'b0;
        chk("r2_ext_set", {31'd0, external_enqueue}, 32'd1);
        actor_idle = 4'hF;
        #1;
        chk("r2_run_nodone", {31'd0, ap_done}, 32'd0);
        tick(); // re-launch START
        actor_idle = 4'h0;
        chk("relaunch_trig", {31'd0, trig_start},       32'd1);
        chk("relaunch_done", {31'd0, ap_done},          32'd0);
        chk("relaunch_ext",  {31'd0, external_enqueue}, 32'd0);
        chk("relaunch_rc",   round_count,               32'd1);
        tick(); // RUN
        chk("r2b_rc",   round_count,         32'd2);
        chk("r2b_trig", {31'd0, trig_start}, 32'd0);
        actor_sync_exec = 4'hF;
        tick();
        chk("r2b_sync", {31'd0, all_sync}, 32'd1);
        enq_strobe = 1'b1;
        tick();
        enq_strobe      = 1'b0;
        actor_sync_exec = 4'h0;
        chk("strobe_wins_sync", {31'd0, external_enqueue}, 32'd1);
        tick();
        chk("sync_clears_ext", {31'd0, external_enqueue}, 32'd0);
        chk("r2b_sync_clr",    {31'd0, all_sync},         32'd0);
        actor_idle = 4'hF;
        tick(); // DONE
        chk("r2_done",    {31'd0, ap_done}, 32'd1);
        chk("r2_done_rc", round_count,      32'd2);
        tick(); // IDLE
        chk("r2_idle_back", {31'd0, ap_idle}, 32'd1);
        chk("r2_done_gone", {31'd0, ap_done}, 32'd0);
        enq_strobe = 1'b1;
        tick();
        enq_strobe = 1'b0;
        chk("idle_strobe_ign", {31'd0, external_enqueue}, 32'd0);
        chk("idle_stays",      {31'd0, ap_idle},          32'd1);

        // Round 3: strobe during DONE sets the flag, next accept clears it
        ap_start = 1'b1;
        tick(); // START
        ap_start   = 1'b0;
        actor_idle = 4'h0;
        tick(); // RUN
        actor_idle = 4'hF;
        tick(); // DONE
        chk("r3_done", {31'd0, ap_done}, 32'd1);
        enq_strobe = 1'b1;
        tick(); // IDLE
        enq_strobe = 1'b0;
        chk("done_strobe_set", {31'd0, external_enqueue}, 32'd1);
        chk("r3_idle",         {31'd0, ap_idle},          32'd1);
        ap_start = 1'b1;
        tick(); // START
        chk("accept_clr_ext", {31'd0, external_enqueue}, 32'd0);
        chk("r4_trig",        {31'd0, trig_start},       32'd1);
        ap_start   = 1'b0;
        actor_idle = 4'h0;
        tick(); // RUN
        chk("r4_run_idle", {31'd0, ap_idle},    32'd0);
        chk("r4_run_rc",   round_count,         32'd1);

        // Asynchronous reset mid-RUN
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_idle", {31'd0, ap_idle},    32'd1);
        chk("midrst_trig", {31'd0, trig_start}, 32'd0);
        chk("midrst_rc",   round_count,         32'd0);
        tick();
        chk("midrst_hold", {31'd0, ap_idle}, 32'd1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
